codestream_out_packer: RTL and testbench
========================================

Name: codestream_out_packer

Overview:
- Downstream stage of jpeg2000_top. Consumes its sparse byte-enabled codestream writes (write_en, output_to_fpga_32) and compacts them into a dense big-endian 32-bit word stream.
- Buffers the words in a FIFO and drains them through a valid/ready master port.
- Once per tile, on frame_end, flushes the partial word, tags the terminating word with a byte count and last, and reports per-tile statistics.

Parameters:
- FIFO_DEPTH, 16, word FIFO depth; power of two, minimum 4.
- PAD_BYTE, 8'h00, fill value for unused byte lanes of the terminating word.

Ports:
- clk_dwt  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset.
- write_en  in  4  byte-lane enables; lane i = output_to_fpga_32[8i+7:8i].
- output_to_fpga_32  in  32  codestream data from jpeg2000_top.
- frame_end  in  1  one-cycle pulse marking the last write of a tile; may coincide with write_en.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts when m_valid&&m_ready.
- m_data  out  32  packed word; first byte of the stream in [31:24].
- m_bytes  out  3  valid bytes in m_data: 4 normally, 0..3 on the terminating word.
- m_last  out  1  marks the terminating word of a tile.
- m_addr  out  16  word index within the current tile.
- frame_bytes  out  32  byte total of the last completed tile, latched at flush.
- frame_cnt  out  5  completed tiles, wraps 31->0.
- ovf_err  out  1  sticky; bytes were dropped.

Behaviour:
- Reset (rst=0, async): all outputs 0, FIFO empty, accumulator empty, FSM in RUN.
- Packing:
  - Lanes are taken in order 3,2,1,0 and only enabled lanes are used; any enable pattern is legal and is compacted.
  - The accumulator holds 0..3 leftover bytes (cnt). Per cycle, leftover plus new bytes is at most 7, so at most one full word is formed, with the oldest byte placed in [31:24].
  - A full word is pushed with m_bytes=4 and m_last=0. The leftover after a push is cnt+n-4.
  - A running byte counter adds n for each accepted cycle.
- FSM states: RUN and FLUSH.
  - RUN, frame_end=1: the same cycle's bytes are packed normally, then the FSM goes to FLUSH.
  - FLUSH: pushes exactly one terminating word.
    - Contains the leftover bytes left-aligned, remaining lanes PAD_BYTE.
    - m_bytes = leftover (0 gives an all-PAD word); m_last=1.
    - Latches frame_bytes = running count. Then clears the accumulator, the running count and the m_addr counter, increments frame_cnt, and returns to RUN.
  - FLUSH with FIFO full: stays in FLUSH until space is available.
  - write_en≠0 in any FLUSH cycle: those bytes are dropped and ovf_err is set.
  - frame_end while in FLUSH: ignored.
- FIFO:
  - Stores {data, bytes, last, addr}. Push and pop in the same cycle are allowed, including when full, since the pop frees the slot first.
  - m_valid = !empty. m_data and the other outputs come from the FIFO head (registered/FWFT); they stay stable while m_valid && !m_ready.
  - m_addr per word is taken from a per-tile word counter at push time: 0,1,2… Pushing the terminating word clears the counter to 0, so the next tile's first word has index 0.
- Overflow (RUN): a full word due while the FIFO is full and not popping → that word is discarded and ovf_err set; the leftover computation proceeds as if the word had been pushed. No backpressure is given upstream.
- Latency: a word completed in cycle t is visible on m_valid at t+1 if the FIFO was empty.
- ovf_err clears only on reset.

Test Plan:
- Contiguous words: write_en=4'hF with data 11223344, then 55667788; frame_end on the second cycle → two words (m_addr 0,1; m_bytes=4), then terminator 00000000 with m_bytes=0, last=1; frame_bytes=8; frame_cnt=1.
- Sparse lanes: write_en=1100 data AABBxxxx, then 0011 data xxxxCCDD, then 0110 data xxEEFFxx; frame_end on the 3rd cycle → word AABBCCDD, then terminator EEFF0000 with m_bytes=2, last=1; frame_bytes=6.
- Seven-byte boundary: leftover 3 (bytes 01 02 03), then write_en=F data 04050607 with frame_end in the same cycle → word 01020304, then terminator 05060700 with m_bytes=3; no bytes lost.
- Backpressure: hold m_ready=0 and stream 20 full words with FIFO_DEPTH=16 → 16 stored, ovf_err=1. Release m_ready → 16 words drain in order with m_data stable while stalled.
- Mid-tile reset: drive rst low during a tile with leftover 2 → all outputs 0 immediately. Next tile after rst high starts at m_addr=0 with frame_cnt=0.
- Multi-tile: 24 tiles of 5 bytes each → per tile one full word plus a terminator with m_bytes=1. Final frame_cnt=24; m_addr restarts at 0 for each tile.

Source files
------------

// File: rtl/codestream_out_packer.sv
// Compacts sparse byte-enabled codestream writes into dense big-endian 32-bit words,
// buffers them in a FWFT FIFO and closes each tile with a byte-counted terminating word.
module codestream_out_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic        clk_dwt,
    input  logic        rst,
    input  logic [3:0]  write_en,
    input  logic [31:0] output_to_fpga_32,
    input  logic        frame_end,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [2:0]  m_bytes,
    output logic        m_last,
    output logic [15:0] m_addr,
    output logic [31:0] frame_bytes,
    output logic [4:0]  frame_cnt,
    output logic        ovf_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 52;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t       state_r, state_nxt_s;
    logic [23:0]  acc_r, acc_nxt_s;
    logic [1:0]   acc_cnt_r, acc_cnt_nxt_s;
    logic [31:0]  run_bytes_r, run_bytes_nxt_s;
    logic [15:0]  word_idx_r, word_idx_nxt_s;
    logic [31:0]  frame_bytes_r;
    logic [4:0]   frame_cnt_r;
    logic         ovf_r;

    logic [55:0]  comb_s;
    logic [2:0]   total_s;
    logic [2:0]   n_s;
    logic [31:0]  term_s;
    logic         push_s;
    logic [EW-1:0] push_entry_s;
    logic         ovf_set_s;
    logic         flush_done_s;

    logic [EW-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   fifo_cnt_r;
    logic          pop_s;
    logic          space_s;
    logic [EW-1:0] head_s;

    // Append this cycle's enabled lanes (3 down to 0) behind the leftover bytes.
    always_comb begin
        comb_s  = {acc_r, 32'h0000_0000};
        total_s = {1'b0, acc_cnt_r};
        for (int i = 3; i >= 0; i--) begin
            if (write_en[i]) begin
                comb_s[55 - 8*int'(total_s) -: 8] = output_to_fpga_32[8*i +: 8];
                total_s = total_s + 3'd1;
            end else begin
                total_s = total_s;
            end
        end
        n_s = total_s - {1'b0, acc_cnt_r};
    end

    // Terminating word: leftover bytes left-aligned, unused lanes padded.
    always_comb begin
        term_s = {4{PAD_BYTE}};
        for (int k = 0; k < 3; k++) begin
            if (k < int'(acc_cnt_r)) begin
                term_s[31 - 8*k -: 8] = acc_r[23 - 8*k -: 8];
            end else begin
                term_s[31 - 8*k -: 8] = PAD_BYTE;
            end
        end
    end

    assign pop_s   = (fifo_cnt_r != {(AW + 1){1'b0}}) && m_ready;
    assign space_s = (fifo_cnt_r != FULL_CNT) || pop_s;

    // Next-state, accumulator update and FIFO push decision.
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        acc_cnt_nxt_s   = acc_cnt_r;
        run_bytes_nxt_s = run_bytes_r;
        word_idx_nxt_s  = word_idx_r;
        push_s          = 1'b0;
        push_entry_s    = {EW{1'b0}};
        ovf_set_s       = 1'b0;
        flush_done_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                run_bytes_nxt_s = run_bytes_r + {29'd0, n_s};
                if (total_s >= 3'd4) begin
                    acc_nxt_s     = comb_s[23:0];
                    acc_cnt_nxt_s = 2'(total_s - 3'd4);
                    // A full word with no room is lost, but the leftover still advances.
                    if (space_s) begin
                        push_s         = 1'b1;
                        push_entry_s   = {comb_s[55:24], 3'd4, 1'b0, word_idx_r};
                        word_idx_nxt_s = word_idx_r + 16'd1;
                    end else begin
                        ovf_set_s = 1'b1;
                    end
                end else begin
                    acc_nxt_s     = comb_s[55:32];
                    acc_cnt_nxt_s = total_s[1:0];
                end
                if (frame_end) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                ovf_set_s = |write_en;
                if (space_s) begin
                    push_s          = 1'b1;
                    push_entry_s    = {term_s, {1'b0, acc_cnt_r}, 1'b1, word_idx_r};
                    acc_nxt_s       = 24'h00_0000;
                    acc_cnt_nxt_s   = 2'd0;
                    run_bytes_nxt_s = 32'd0;
                    word_idx_nxt_s  = 16'd0;
                    flush_done_s    = 1'b1;
                    state_nxt_s     = ST_RUN;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Packer state, accumulator and per-tile counters.
    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_RUN;
            acc_r       <= 24'h00_0000;
            acc_cnt_r   <= 2'd0;
            run_bytes_r <= 32'd0;
            word_idx_r  <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            acc_cnt_r   <= acc_cnt_nxt_s;
            run_bytes_r <= run_bytes_nxt_s;
            word_idx_r  <= word_idx_nxt_s;
        end
    end

    // Tile statistics and sticky overflow flag.
    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            frame_bytes_r <= 32'd0;
            frame_cnt_r   <= 5'd0;
            ovf_r         <= 1'b0;
        end else begin
            ovf_r <= ovf_r | ovf_set_s;
            if (flush_done_s) begin
                frame_bytes_r <= run_bytes_r;
                frame_cnt_r   <= frame_cnt_r + 5'd1;
            end
        end
    end

    // Word FIFO; a simultaneous pop frees the slot so a push into a full FIFO succeeds.
    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_r[i] <= {EW{1'b0}};
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            fifo_cnt_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + (AW + 1)'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - (AW + 1)'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign head_s      = mem_r[rd_ptr_r];
    assign m_valid     = (fifo_cnt_r != {(AW + 1){1'b0}});
    assign m_data      = head_s[51:20];
    assign m_bytes     = head_s[19:17];
    assign m_last      = head_s[16];
    assign m_addr      = head_s[15:0];
    assign frame_bytes = frame_bytes_r;
    assign frame_cnt   = frame_cnt_r;
    assign ovf_err     = ovf_r;

endmodule

// File: tb/tb_codestream_out_packer.sv
// Directed scoreboard bench for codestream_out_packer: a byte-level model predicts every
// output word, which a negedge monitor compares as the consumer accepts it.
module tb_codestream_out_packer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
        logic [15:0] addr;
    } word_t;

    logic        clk_dwt = 1'b0;
    logic        rst;
    logic [3:0]  write_en;
    logic [31:0] output_to_fpga_32;
    logic        frame_end;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  m_bytes;
    logic        m_last;
    logic [15:0] m_addr;
    logic [31:0] frame_bytes;
    logic [4:0]  frame_cnt;
    logic        ovf_err;

    always #5 clk_dwt = ~clk_dwt;

    codestream_out_packer #(.FIFO_DEPTH(DEPTH), .PAD_BYTE(8'h00)) dut (
        .clk_dwt(clk_dwt), .rst(rst), .write_en(write_en),
        .output_to_fpga_32(output_to_fpga_32), .frame_end(frame_end),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_bytes(m_bytes),
        .m_last(m_last), .m_addr(m_addr), .frame_bytes(frame_bytes),
        .frame_cnt(frame_cnt), .ovf_err(ovf_err)
    );

    word_t      exp_q[$];
    logic [7:0] mb_q[$];
    int         model_addr;
    int         n_assert;
    int         n_fail;
    logic       prev_stall;
    word_t      prev_w;
    word_t      got_w;
    word_t      exp_w;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of writes and predict the words it produces.
    task automatic drive(input logic [3:0] we, input logic [31:0] d, input logic fe);
        word_t w;
        @(posedge clk_dwt); #1;
        write_en = we;
        output_to_fpga_32 = d;
        frame_end = fe;
        for (int i = 3; i >= 0; i--) begin
            if (we[i]) mb_q.push_back(d[8*i +: 8]);
        end
        if (mb_q.size() >= 4) begin
            w.data  = {mb_q[0], mb_q[1], mb_q[2], mb_q[3]};
            w.bytes = 3'd4;
            w.last  = 1'b0;
            w.addr  = 16'(model_addr);
            repeat (4) void'(mb_q.pop_front());
            if (!(!m_ready && exp_q.size() >= DEPTH)) begin
                exp_q.push_back(w);
                model_addr++;
            end
        end
        if (fe) begin
            w.data = 32'h0;
            for (int k = 0; k < 3; k++) begin
                if (k < mb_q.size()) w.data[31 - 8*k -: 8] = mb_q[k];
            end
            w.bytes = 3'(mb_q.size());
            w.last  = 1'b1;
            w.addr  = 16'(model_addr);
            exp_q.push_back(w);
            model_addr = 0;
            mb_q.delete();
        end
    endtask

    task automatic idle();
        @(posedge clk_dwt); #1;
        write_en = 4'h0;
        output_to_fpga_32 = 32'h0;
        frame_end = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk_dwt); #2;
            if (exp_q.size() == 0 && !m_valid) done = 1'b1;
        end
        check(tag, {31'(exp_q.size()), m_valid}, 64'd0);
    endtask

    // Consumer-side monitor: scoreboard compare on acceptance, hold check while stalled.
    always @(negedge clk_dwt) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            got_w = {m_data, m_bytes, m_last, m_addr};
            if (prev_stall) check("stall_hold", {m_valid, got_w}, {1'b1, prev_w});
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {1'b1, got_w}, 64'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("m_data", m_data, exp_w.data);
                    check("m_bytes_last_addr", {m_bytes, m_last, m_addr},
                          {exp_w.bytes, exp_w.last, exp_w.addr});
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_w = got_w;
        end
    end

    initial begin
        n_assert = 0;
        n_fail = 0;
        model_addr = 0;
        prev_stall = 1'b0;
        rst = 1'b0;
        write_en = 4'h0;
        output_to_fpga_32 = 32'h0;
        frame_end = 1'b0;
        m_ready = 1'b1;
        #1;
        check("reset_valid", m_valid, 1'b0);
        check("reset_head", {m_data, m_bytes, m_last, m_addr}, 64'd0);
        check("reset_stats", {frame_bytes, frame_cnt, ovf_err}, 64'd0);
        repeat (2) @(posedge clk_dwt);
        #1 rst = 1'b1;

        // Contiguous words with frame_end on the second write.
        drive(4'hF, 32'h1122_3344, 1'b0);
        drive(4'hF, 32'h5566_7788, 1'b1);
        check("t1_latency_valid", m_valid, 1'b1);
        check("t1_latency_data", m_data, 32'h1122_3344);
        idle();
        wait_drain("t1_drain");
        check("t1_frame_bytes", frame_bytes, 32'd8);
        check("t1_frame_cnt", frame_cnt, 5'd1);

        // Sparse lanes compacted.
        drive(4'b1100, 32'hAABB_1234, 1'b0);
        drive(4'b0011, 32'h9876_CCDD, 1'b0);
        drive(4'b0110, 32'h11EE_FF22, 1'b1);
        idle();
        wait_drain("t2_drain");
        check("t2_frame_bytes", frame_bytes, 32'd6);
        check("t2_frame_cnt", frame_cnt, 5'd2);

        // Leftover 3 plus 4 new bytes: the seven-byte boundary.
        drive(4'b1110, 32'h0102_03FF, 1'b0);
        drive(4'hF, 32'h0405_0607, 1'b1);
        idle();
        wait_drain("t3_drain");
        check("t3_frame_bytes", frame_bytes, 32'd7);
        check("t3_frame_cnt", frame_cnt, 5'd3);
        check("t3_no_ovf", ovf_err, 1'b0);

        // Backpressure: 20 words into a 16-deep FIFO, then release.
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(4'hF, {8'(i), 8'(i + 1), 8'(i + 2), 8'(i + 3)}, 1'b0);
        end
        idle();
        check("t4_ovf_err", ovf_err, 1'b1);
        check("t4_valid_stalled", m_valid, 1'b1);
        repeat (3) idle();
        m_ready = 1'b1;
        wait_drain("t4_drain");
        drive(4'h0, 32'h0, 1'b1);
        idle();
        wait_drain("t4_term_drain");
        check("t4_frame_cnt", frame_cnt, 5'd4);

        // Mid-tile reset with a word queued and leftover 2.
        m_ready = 1'b0;
        drive(4'hF, 32'hA1A2_A3A4, 1'b0);
        drive(4'b1100, 32'hB1B2_0000, 1'b0);
        idle();
        check("t5_pre_valid", m_valid, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_rst_head", {m_valid, m_data, m_bytes, m_last, m_addr}, 64'd0);
        check("t5_rst_stats", {frame_bytes, frame_cnt, ovf_err}, 64'd0);
        exp_q.delete();
        mb_q.delete();
        model_addr = 0;
        @(posedge clk_dwt); #1;
        rst = 1'b1;
        m_ready = 1'b1;

        // 24 tiles of 5 bytes: one full word plus a 1-byte terminator each.
        for (int t = 0; t < 24; t++) begin
            drive(4'hF, {8'(t), 8'(t + 16), 8'(t + 32), 8'(t + 48)}, 1'b0);
            drive(4'(1 << (t % 4)), {4{8'(t) ^ 8'h5A}}, 1'b1);
            idle();
        end
        wait_drain("t6_drain");
        check("t6_frame_cnt", frame_cnt, 5'd24);
        check("t6_frame_bytes", frame_bytes, 32'd5);
        check("t6_no_ovf", ovf_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
